// File: rtl/cobalt_pkg.sv
// Shared core definitions: default widths, integer opcodes and
// the issue-queue entry layout for the default configuration.
package cobalt_pkg;

  localparam int TAG_W_DEF  = 6;
  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF   = 3;
  localparam int IQ_DEPTH   = 8;

  localparam logic [OP_W_DEF-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W_DEF-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W_DEF-1:0] OP_AND = 3'd2;
  localparam logic [OP_W_DEF-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W_DEF-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W_DEF-1:0] OP_SLT = 3'd5;
  localparam logic [OP_W_DEF-1:0] OP_SLL = 3'd6;
  localparam logic [OP_W_DEF-1:0] OP_SRL = 3'd7;

  typedef struct packed {
    logic [OP_W_DEF-1:0]   opcode;
    logic [TAG_W_DEF-1:0]  rdtag;
    logic [TAG_W_DEF-1:0]  rstag;
    logic [TAG_W_DEF-1:0]  rttag;
    logic [DATA_W_DEF-1:0] rsdata;
    logic [DATA_W_DEF-1:0] rtdata;
    logic                  rsvalid;
    logic                  rtvalid;
  } iq_entry_t;

  localparam int IQ_ENTRY_W  = $bits(iq_entry_t);
  localparam int IQ_RTV_OFS  = 0;
  localparam int IQ_RSV_OFS  = 1;
  localparam int IQ_RTD_OFS  = 2;
  localparam int IQ_RSD_OFS  = IQ_RTD_OFS + DATA_W_DEF;

endpackage

// File: rtl/iq_oldest_select.sv
// Priority encoder: lowest set bit of the ready vector wins,
// since entry 0 is always the oldest instruction.
module iq_oldest_select #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  ready_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (ready_i[i]) begin
        found_o = 1'b1;
        idx_o   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/issue_queue_int.sv
// Compacting integer issue queue: oldest-ready select, CDB wakeup,
// shift-down on issue and flush on mispredict.
module issue_queue_int
  import cobalt_pkg::*;
#(
  parameter int DEPTH  = IQ_DEPTH,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              dispatch_en,
  output logic              dispatch_ready,
  input  logic [OP_W-1:0]   dispatch_opcode,
  input  logic [TAG_W-1:0]  dispatch_rdtag,
  input  logic [TAG_W-1:0]  dispatch_rstag,
  input  logic [TAG_W-1:0]  dispatch_rttag,
  input  logic [DATA_W-1:0] dispatch_rsdata,
  input  logic [DATA_W-1:0] dispatch_rtdata,
  input  logic              dispatch_rsvalid,
  input  logic              dispatch_rtvalid,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [OP_W-1:0]   issue_opcode,
  output logic [TAG_W-1:0]  issue_rdtag,
  output logic [DATA_W-1:0] issue_rsdata,
  output logic [DATA_W-1:0] issue_rtdata,
  output logic [CW-1:0]     count
);

  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [TAG_W-1:0]  rdtag;
    logic [TAG_W-1:0]  rstag;
    logic [TAG_W-1:0]  rttag;
    logic [DATA_W-1:0] rsdata;
    logic [DATA_W-1:0] rtdata;
    logic              rsvalid;
    logic              rtvalid;
  } entry_t;

  entry_t        ent_q [DEPTH];
  entry_t        ent_d [DEPTH];
  entry_t        woke  [DEPTH+1];
  entry_t        new_e;
  entry_t        sel_e;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] wpos;
  logic [DEPTH-1:0] rdy;
  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic          dfire, ifire;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = (CW'(i) < count_q) &&
               ent_q[i].rsvalid && ent_q[i].rtvalid;
    end
  end

  iq_oldest_select #(
    .N  (DEPTH),
    .IW (IW)
  ) u_sel (
    .ready_i (rdy),
    .found_o (sel_found),
    .idx_o   (sel_idx)
  );

  assign sel_e          = sel_found ? ent_q[sel_idx] : '0;
  assign issue_valid    = sel_found;
  assign issue_opcode   = sel_e.opcode;
  assign issue_rdtag    = sel_e.rdtag;
  assign issue_rsdata   = sel_e.rsdata;
  assign issue_rtdata   = sel_e.rtdata;
  assign count          = count_q;
  // Registered count only, so dispatch never waits on the select path.
  assign dispatch_ready = count_q < CW'(DEPTH);
  assign dfire          = dispatch_en & dispatch_ready;
  assign ifire          = issue_valid & issue_ready;
  assign wpos           = ifire ? count_q - 1'b1 : count_q;

  always_comb begin
    new_e = '{
      opcode:  dispatch_opcode,
      rdtag:   dispatch_rdtag,
      rstag:   dispatch_rstag,
      rttag:   dispatch_rttag,
      rsdata:  dispatch_rsdata,
      rtdata:  dispatch_rtdata,
      rsvalid: dispatch_rsvalid,
      rtvalid: dispatch_rtvalid
    };
    if (cdb_valid && !new_e.rsvalid && new_e.rstag == cdb_tag) begin
      new_e.rsvalid = 1'b1;
      new_e.rsdata  = cdb_data;
    end
    if (cdb_valid && !new_e.rtvalid && new_e.rttag == cdb_tag) begin
      new_e.rtvalid = 1'b1;
      new_e.rtdata  = cdb_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = ent_q[i];
      if (cdb_valid && CW'(i) < count_q) begin
        if (!woke[i].rsvalid && woke[i].rstag == cdb_tag) begin
          woke[i].rsvalid = 1'b1;
          woke[i].rsdata  = cdb_data;
        end
        if (!woke[i].rtvalid && woke[i].rttag == cdb_tag) begin
          woke[i].rtvalid = 1'b1;
          woke[i].rtdata  = cdb_data;
        end
      end
    end
    woke[DEPTH] = '0;
  end

  // Wakeup is applied before the shift so moving entries keep it.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (ifire && i >= int'(sel_idx)) ent_d[i] = woke[i+1];
      else                             ent_d[i] = woke[i];
      if (dfire && CW'(i) == wpos)     ent_d[i] = new_e;
      if (flush)                       ent_d[i] = '0;
    end
    count_d = count_q + CW'(dfire) - CW'(ifire);
    if (flush) count_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: tb/tb_issue_queue_int.sv
// Bench for issue_queue_int: vector table plus directed sequences,
// issued instructions checked against an in-order scoreboard.
module tb_issue_queue_int;
  import cobalt_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        dispatch_en;
  logic        dispatch_ready;
  logic [2:0]  dispatch_opcode;
  logic [5:0]  dispatch_rdtag, dispatch_rstag, dispatch_rttag;
  logic [31:0] dispatch_rsdata, dispatch_rtdata;
  logic        dispatch_rsvalid, dispatch_rtvalid;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_opcode;
  logic [5:0]  issue_rdtag;
  logic [31:0] issue_rsdata, issue_rtdata;
  logic [3:0]  count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  op;
    logic [5:0]  rd;
    logic [31:0] rs, rt;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [5:0]  rd, rst, rtt;
    logic [31:0] rsd, rtd;
    logic        rsv, rtv;
    logic        cv;
    logic [5:0]  ct;
    logic [31:0] cd;
    logic [31:0] ers, ert;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  issue_queue_int dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .dispatch_en      (dispatch_en),
    .dispatch_ready   (dispatch_ready),
    .dispatch_opcode  (dispatch_opcode),
    .dispatch_rdtag   (dispatch_rdtag),
    .dispatch_rstag   (dispatch_rstag),
    .dispatch_rttag   (dispatch_rttag),
    .dispatch_rsdata  (dispatch_rsdata),
    .dispatch_rtdata  (dispatch_rtdata),
    .dispatch_rsvalid (dispatch_rsvalid),
    .dispatch_rtvalid (dispatch_rtvalid),
    .cdb_valid        (cdb_valid),
    .cdb_tag          (cdb_tag),
    .cdb_data         (cdb_data),
    .issue_valid      (issue_valid),
    .issue_ready      (issue_ready),
    .issue_opcode     (issue_opcode),
    .issue_rdtag      (issue_rdtag),
    .issue_rsdata     (issue_rsdata),
    .issue_rtdata     (issue_rtdata),
    .count            (count)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic check_issue();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL issue_unexpected got rd=%h exp none", issue_rdtag);
    end else begin
      e = sb.pop_front();
      if (issue_opcode !== e.op || issue_rdtag !== e.rd ||
          issue_rsdata !== e.rs || issue_rtdata !== e.rt) begin
        failures++;
        $display("FAIL issue got=%h/%h/%h/%h exp=%h/%h/%h/%h",
                 issue_opcode, issue_rdtag, issue_rsdata,
                 issue_rtdata, e.op, e.rd, e.rs, e.rt);
      end
    end
  endtask

  // Called at a negedge: record any issue firing at the next posedge.
  task automatic tick();
    if (issue_valid && issue_ready) check_issue();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drv(logic [2:0] op, logic [5:0] rd,
                     logic [5:0] rst, logic [31:0] rsd, logic rsv,
                     logic [5:0] rtt, logic [31:0] rtd, logic rtv);
    dispatch_en      = 1'b1;
    dispatch_opcode  = op;
    dispatch_rdtag   = rd;
    dispatch_rstag   = rst;
    dispatch_rsdata  = rsd;
    dispatch_rsvalid = rsv;
    dispatch_rttag   = rtt;
    dispatch_rtdata  = rtd;
    dispatch_rtvalid = rtv;
  endtask

  task automatic cdb(logic v, logic [5:0] t, logic [31:0] d);
    cdb_valid = v;
    cdb_tag   = t;
    cdb_data  = d;
  endtask

  task automatic push(logic [2:0] op, logic [5:0] rd,
                      logic [31:0] rs, logic [31:0] rt);
    sb.push_back('{op: op, rd: rd, rs: rs, rt: rt});
  endtask

  initial begin
    vecs[0] = '{OP_ADD, 6'd1, 6'd1, 6'd2, 32'h11, 32'h22,
                1'b1, 1'b1, 1'b0, 6'd0, 32'h0, 32'h11, 32'h22};
    vecs[1] = '{OP_SUB, 6'd2, 6'd3, 6'd4, 32'hA, 32'hB,
                1'b1, 1'b1, 1'b0, 6'd0, 32'h0, 32'hA, 32'hB};
    vecs[2] = '{OP_AND, 6'd3, 6'd7, 6'd8, 32'h0, 32'h5,
                1'b0, 1'b1, 1'b1, 6'd7, 32'hBEEF, 32'hBEEF, 32'h5};
    vecs[3] = '{OP_OR, 6'd4, 6'd9, 6'd9, 32'h0, 32'h0,
                1'b0, 1'b0, 1'b1, 6'd9, 32'hCAFE, 32'hCAFE, 32'hCAFE};
    vecs[4] = '{OP_SLT, 6'd5, 6'd12, 6'd13, 32'h77, 32'h88,
                1'b1, 1'b1, 1'b1, 6'd12, 32'hDEAD, 32'h77, 32'h88};
    vecs[5] = '{OP_XOR, 6'd6, 6'd1, 6'd0, 32'h66, 32'h0,
                1'b1, 1'b0, 1'b1, 6'd0, 32'h1000, 32'h66, 32'h1000};

    reset = 1'b0;
    flush = 1'b0;
    issue_ready = 1'b1;
    drv(OP_ADD, 0, 0, 0, 0, 0, 0, 0);
    dispatch_en = 1'b0;
    cdb(1'b0, 6'd0, 32'h0);
    @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_dready", 32'(dispatch_ready), 1);
    chk("rst_ivalid", 32'(issue_valid), 0);
    chk("rst_irs", issue_rsdata, 0);
    reset = 1'b1;
    @(negedge clk);

    // Back-to-back stream: each entry issues one cycle after dispatch.
    for (int i = 0; i < 6; i++) begin
      drv(vecs[i].op, vecs[i].rd, vecs[i].rst, vecs[i].rsd,
          vecs[i].rsv, vecs[i].rtt, vecs[i].rtd, vecs[i].rtv);
      cdb(vecs[i].cv, vecs[i].ct, vecs[i].cd);
      push(vecs[i].op, vecs[i].rd, vecs[i].ers, vecs[i].ert);
      tick();
      chk($sformatf("vec%0d_count", i), 32'(count), 1);
      chk($sformatf("vec%0d_ivalid", i), 32'(issue_valid), 1);
    end
    dispatch_en = 1'b0;
    cdb(1'b0, 6'd0, 32'h0);
    for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
    chk("drain_sb", 32'(sb.size()), 0);
    chk("drain_count", 32'(count), 0);

    // Younger ready instruction bypasses older waiting one.
    drv(OP_ADD, 6'd20, 6'd5, 32'h0, 1'b0, 6'd6, 32'h2, 1'b1);
    tick();
    chk("ooo_count1", 32'(count), 1);
    chk("ooo_wait", 32'(issue_valid), 0);
    drv(OP_SUB, 6'd21, 6'd1, 32'h3, 1'b1, 6'd2, 32'h4, 1'b1);
    push(OP_SUB, 6'd21, 32'h3, 32'h4);
    tick();
    chk("ooo_count2", 32'(count), 2);
    chk("ooo_first", 32'(issue_rdtag), 21);
    dispatch_en = 1'b0;
    cdb(1'b1, 6'd5, 32'h1234);
    push(OP_ADD, 6'd20, 32'h1234, 32'h2);
    tick();
    cdb(1'b0, 6'd0, 32'h0);
    chk("ooo_count3", 32'(count), 1);
    chk("ooo_wake_rs", issue_rsdata, 32'h1234);
    tick();
    chk("ooo_count4", 32'(count), 0);

    // Fill with waiting entries.
    for (int i = 0; i < 8; i++) begin
      drv(3'(i), 6'(30 + i), 6'(40 + i), 32'h0, 1'b0,
          6'd63, 32'(i), 1'b1);
      tick();
    end
    chk("full_count", 32'(count), 8);
    chk("full_dready", 32'(dispatch_ready), 0);
    drv(OP_ADD, 6'd59, 6'd1, 32'h1, 1'b1, 6'd2, 32'h2, 1'b1);
    tick();
    dispatch_en = 1'b0;
    chk("full_nodisp", 32'(count), 8);
    cdb(1'b1, 6'd43, 32'h3333);
    push(3'd3, 6'd33, 32'h3333, 32'd3);
    tick();
    chk("wake3_sel", 32'(issue_rdtag), 33);
    // Entry 5 wakes while it shifts down into slot 4.
    cdb(1'b1, 6'd45, 32'h5555);
    push(3'd5, 6'd35, 32'h5555, 32'd5);
    tick();
    cdb(1'b0, 6'd0, 32'h0);
    chk("shift_count", 32'(count), 7);
    chk("shift_dready", 32'(dispatch_ready), 1);
    chk("shift_wake_sel", 32'(issue_rdtag), 35);
    tick();
    chk("shift2_count", 32'(count), 6);
    cdb(1'b1, 6'd44, 32'h4444);
    push(3'd4, 6'd34, 32'h4444, 32'd4);
    tick();
    cdb(1'b0, 6'd0, 32'h0);
    tick();
    chk("pre_flush_count", 32'(count), 5);

    // Flush wins over a same-cycle dispatch and wakeup.
    flush = 1'b1;
    drv(OP_OR, 6'd58, 6'd1, 32'h1, 1'b1, 6'd2, 32'h2, 1'b1);
    cdb(1'b1, 6'd40, 32'h4040);
    issue_ready = 1'b0;
    tick();
    flush = 1'b0;
    dispatch_en = 1'b0;
    cdb(1'b0, 6'd0, 32'h0);
    issue_ready = 1'b1;
    chk("flush_count", 32'(count), 0);
    chk("flush_ivalid", 32'(issue_valid), 0);
    tick();
    chk("flush_dropped", 32'(issue_valid), 0);

    // Backpressure: outputs hold while the ALU stalls.
    issue_ready = 1'b0;
    drv(OP_SLL, 6'd50, 6'd1, 32'h5050, 1'b1, 6'd2, 32'h6060, 1'b1);
    tick();
    dispatch_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("hold%0d_ivalid", k), 32'(issue_valid), 1);
      chk($sformatf("hold%0d_rd", k), 32'(issue_rdtag), 50);
      chk($sformatf("hold%0d_rs", k), issue_rsdata, 32'h5050);
      tick();
    end
    issue_ready = 1'b1;
    push(OP_SLL, 6'd50, 32'h5050, 32'h6060);
    tick();
    chk("hold_release_count", 32'(count), 0);
    chk("hold_single", 32'(issue_valid), 0);

    // Asynchronous reset between edges.
    issue_ready = 1'b0;
    drv(OP_ADD, 6'd60, 6'd1, 32'h1, 1'b1, 6'd2, 32'h2, 1'b1);
    tick();
    drv(OP_ADD, 6'd61, 6'd1, 32'h1, 1'b1, 6'd2, 32'h2, 1'b1);
    tick();
    dispatch_en = 1'b0;
    chk("arst_pre_count", 32'(count), 2);
    #2 reset = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_ivalid", 32'(issue_valid), 0);
    chk("arst_dready", 32'(dispatch_ready), 1);
    chk("arst_rd", 32'(issue_rdtag), 0);
    @(negedge clk);
    reset = 1'b1;
    issue_ready = 1'b1;
    tick();
    chk("arst_post_count", 32'(count), 0);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/issue_queue_int.md
Name: issue_queue_int

Overview:
Parametrised integer issue queue for the out-of-order core. It sits between dispatch and the integer ALU and holds up to DEPTH renamed instructions. It snoops the CDB to wake waiting source operands. Each cycle it issues the oldest instruction whose operands are both ready, and it accepts a flush on branch mispredict.

Parameters:
DEPTH, 8, number of entries (2..16)
TAG_W, 6, physical/ROB tag width
DATA_W, 32, operand width
OP_W, 3, integer opcode width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
flush  in  1  synchronous clear of all entries (mispredict)
dispatch_en  in  1  dispatch offers an instruction
dispatch_ready  out  1  queue can accept this cycle
dispatch_opcode  in  OP_W  ALU opcode
dispatch_rdtag  in  TAG_W  destination tag
dispatch_rstag  in  TAG_W  rs producer tag
dispatch_rttag  in  TAG_W  rt producer tag
dispatch_rsdata  in  DATA_W  rs value when rsvalid
dispatch_rtdata  in  DATA_W  rt value when rtvalid
dispatch_rsvalid  in  1  rs value present
dispatch_rtvalid  in  1  rt value present
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  broadcast tag
cdb_data  in  DATA_W  broadcast value
issue_valid  out  1  an entry is selected for issue
issue_ready  in  1  ALU accepts this cycle
issue_opcode  out  OP_W  selected opcode
issue_rdtag  out  TAG_W  selected destination tag
issue_rsdata  out  DATA_W  selected rs value
issue_rtdata  out  DATA_W  selected rt value
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Storage: entries 0..DEPTH-1. Entry 0 is oldest. Occupied entries are always contiguous 0..count-1 (compacting queue).
- Entry fields: opcode, rdtag, rstag, rttag, rsdata, rtdata, rsvalid, rtvalid.
- Reset (reset=0, async): count=0 and all entries empty. Outputs then read dispatch_ready=1, issue_valid=0, count=0, and issue_* data=0. Reset asserted mid-operation takes effect immediately and discards everything.
- dispatch_ready = (count < DEPTH). It is combinational from registered count only; it does not account for a same-cycle issue, which avoids a dispatch/issue loop.
- Dispatch fire = dispatch_en & dispatch_ready.
- Select: the lowest index i < count with rsvalid & rtvalid, using registered bits only. A CDB wakeup becomes visible to select in the next cycle.
- issue_valid = a selected entry exists. issue_* fields are combinational from the selected entry, and are 0 when none is selected.
- Issue fire = issue_valid & issue_ready. Outputs hold stable while issue_ready=0.
- On issue fire at index s: entries s+1..count-1 shift down by one.
- New dispatch is written at index count-1 if issue fires in the same cycle, otherwise at index count.
- count_next = count + dispatch_fire - issue_fire.
- CDB wakeup applies when cdb_valid=1:
  - Stored entries: every occupied entry with rsvalid=0 and rstag==cdb_tag sets rsvalid=1 and rsdata=cdb_data; likewise for rt.
  - Shifting entries: an entry being shifted receives the wakeup in its new position in the same cycle.
- Dispatch bypass: if a dispatched operand has valid=0 and its tag equals cdb_tag with cdb_valid=1, the entry is written with valid=1 and data=cdb_data. The issued entry is not updated.
- Both operands can wake on one broadcast (rstag==rttag).
- Flush=1: count_next=0 and all entries are cleared. Flush overrides dispatch and issue in the same cycle, so the dispatched instruction is dropped. issue_valid is still computed combinationally, and the ALU must ignore it during a flush.
- Full with simultaneous issue: dispatch_ready=0, so no dispatch that cycle.
- Empty: issue_valid=0, and a dispatched ready instruction can issue no earlier than the next cycle.
- Tags are opaque and no tag value is special.

Decomposition:
- Shared package cobalt_pkg holds:
  - TAG_W and DATA_W defaults;
  - integer opcode localparams (ADD, SUB, AND, OR, SLT, ...);
  - the issue-queue entry struct/field offsets.
- One natural sub-module, iq_oldest_select: a DEPTH-wide priority encoder from a ready vector to a one-hot/index plus a found flag.

Test Plan:
- Reset, then dispatch 3 instructions with both operands valid and issue_ready=1 -> they issue in order on cycles +1, +2, +3, and count returns to 0.
- Dispatch A (rs waiting on tag 5), then B (ready) -> B issues first. cdb_valid with tag=5, data=0x1234 -> A issues the next cycle with issue_rsdata=0x1234.
- Dispatch with rstag=7 invalid while cdb_tag=7, cdb_data=0xBEEF, cdb_valid=1 in the same cycle -> the entry issues the next cycle with rsdata=0xBEEF.
- Fill to DEPTH=8 with waiting entries -> dispatch_ready=0. Wake entry 3 and issue it -> entries 4..7 shift down, count goes to 7, and dispatch_ready=1.
- Hold issue_ready=0 for 4 cycles with a ready entry -> issue_* stays stable and issue_valid stays 1. Release -> a single issue occurs.
- With count=5, assert flush together with dispatch_en -> count=0 on the next cycle and issue_valid=0. Asserting reset=0 between clock edges clears the queue immediately.
